// File: rtl/idu_redirect_arb.sv
// ============================================================================
// Module   : idu_redirect_arb
// Purpose  : Picks the oldest BJU mispredict and releases it as a PC redirect
//            when it commits. Traps pre-empt it. Optional perf counters are
//            built under the macro IDU_REDIRECT_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module idu_redirect_arb #(
    parameter int ROB_IDX_W    = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_clk,
    input  logic                 bju0_vld,
    input  logic [ROB_IDX_W-1:0] bju0_rob_idx,
    input  logic [63:0]          bju0_addr,
    input  logic                 bju1_vld,
    input  logic [ROB_IDX_W-1:0] bju1_rob_idx,
    input  logic [63:0]          bju1_addr,
    input  logic [ROB_IDX_W-1:0] rob_head_idx,
    input  logic                 rob_commit_vld,
    input  logic [ROB_IDX_W-1:0] rob_commit_idx,
    input  logic                 exc_vld,
    input  logic [63:0]          exc_addr,
    output logic                 redirect_vld,
    output logic [63:0]          redirect_addr,
    output logic                 flush,
    output logic                 y_stall_ctrl,
    output logic [31:0]          perf_redirect_cnt,
    output logic [31:0]          perf_flush_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REDIR = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [ROB_IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [63:0]          pend_addr_q, pend_addr_d;
    logic [63:0]          redir_addr_q, redir_addr_d;

    // Ages are distances from the ROB head, so wrapped subtraction orders them.
    logic [ROB_IDX_W-1:0] w_age0;
    logic [ROB_IDX_W-1:0] w_age1;
    logic [ROB_IDX_W-1:0] w_age_pend;
    logic [ROB_IDX_W-1:0] w_win_age;
    logic [ROB_IDX_W-1:0] w_win_idx;
    logic [63:0]          w_win_addr;
    logic                 w_sel1;
    logic                 w_win_vld;
    logic                 w_take;
    logic                 w_commit_match;

    assign w_age0     = bju0_rob_idx - rob_head_idx;
    assign w_age1     = bju1_rob_idx - rob_head_idx;
    assign w_age_pend = pend_idx_q - rob_head_idx;

    // Port 0 wins ties, so port 1 needs a strictly smaller age.
    assign w_sel1     = bju1_vld & (~bju0_vld | (w_age1 < w_age0));
    assign w_win_vld  = bju0_vld | bju1_vld;
    assign w_win_idx  = w_sel1 ? bju1_rob_idx : bju0_rob_idx;
    assign w_win_addr = w_sel1 ? bju1_addr    : bju0_addr;
    assign w_win_age  = w_sel1 ? w_age1       : w_age0;

    assign w_take = (state_q == S_IDLE) & w_win_vld &
                    (~pend_vld_q | (w_win_age < w_age_pend));

    assign w_commit_match = rob_commit_vld & pend_vld_q &
                            (rob_commit_idx == pend_idx_q) & (state_q == S_IDLE);

    // Pending slot and redirect target
    always_comb begin
        pend_vld_d   = pend_vld_q;
        pend_idx_d   = pend_idx_q;
        pend_addr_d  = pend_addr_q;
        redir_addr_d = redir_addr_q;
        if (exc_vld) begin
            pend_vld_d   = 1'b0;
            redir_addr_d = exc_addr;
        end else if (w_commit_match) begin
            pend_vld_d   = 1'b0;
            redir_addr_d = pend_addr_q;
        end else if (w_take) begin
            pend_vld_d  = 1'b1;
            pend_idx_d  = w_win_idx;
            pend_addr_d = w_win_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            pend_vld_q   <= 1'b0;
            pend_idx_q   <= '0;
            pend_addr_q  <= 64'h0;
            redir_addr_q <= 64'h0;
        end else begin
            pend_vld_q   <= pend_vld_d;
            pend_idx_q   <= pend_idx_d;
            pend_addr_q  <= pend_addr_d;
            redir_addr_q <= redir_addr_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_commit_match) begin
                    state_d = S_REDIR;
                end
            end
            S_REDIR: begin
                state_d = S_FLUSH;
                cnt_d   = C_FLUSH_LOAD;
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (exc_vld) begin
            state_d = S_REDIR;
            cnt_d   = C_FLUSH_LOAD;
        end
    end

    // FSM outputs
    always_comb begin
        redirect_vld  = (state_q == S_REDIR);
        flush         = (state_q != S_IDLE);
        y_stall_ctrl  = (state_q != S_IDLE);
        redirect_addr = redir_addr_q;
    end

`ifdef IDU_REDIRECT_PERF_EN
    logic [31:0] perf_redir_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            perf_redir_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            if (redirect_vld) begin
                perf_redir_q <= perf_redir_q + 32'd1;
            end
            if (flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_redirect_cnt = perf_redir_q;
    assign perf_flush_cnt    = perf_flush_q;
`else
    assign perf_redirect_cnt = 32'h0;
    assign perf_flush_cnt    = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idu_redirect_arb.sv
// ============================================================================
// Module   : tb_idu_redirect_arb
// Purpose  : Scoreboard bench for idu_redirect_arb with directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_idu_redirect_arb;

    localparam int C_W = 5;
    localparam int C_F = 2;

    logic           clk;
    logic           rst_clk;
    logic           bju0_vld, bju1_vld, rob_commit_vld, exc_vld;
    logic [C_W-1:0] bju0_rob_idx, bju1_rob_idx, rob_head_idx, rob_commit_idx;
    logic [63:0]    bju0_addr, bju1_addr, exc_addr;
    logic           redirect_vld, flush, y_stall_ctrl;
    logic [63:0]    redirect_addr;
    logic [31:0]    perf_redirect_cnt, perf_flush_cnt;

    idu_redirect_arb #(.ROB_IDX_W(C_W), .FLUSH_CYCLES(C_F)) u_dut (
        .clk               (clk),
        .rst_clk           (rst_clk),
        .bju0_vld          (bju0_vld),
        .bju0_rob_idx      (bju0_rob_idx),
        .bju0_addr         (bju0_addr),
        .bju1_vld          (bju1_vld),
        .bju1_rob_idx      (bju1_rob_idx),
        .bju1_addr         (bju1_addr),
        .rob_head_idx      (rob_head_idx),
        .rob_commit_vld    (rob_commit_vld),
        .rob_commit_idx    (rob_commit_idx),
        .exc_vld           (exc_vld),
        .exc_addr          (exc_addr),
        .redirect_vld      (redirect_vld),
        .redirect_addr     (redirect_addr),
        .flush             (flush),
        .y_stall_ctrl      (y_stall_ctrl),
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_flush_cnt    (perf_flush_cnt)
    );

    typedef struct {
        logic [63:0] addr;
        int          cyc;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_clk && redirect_vld) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_redirect: got addr %h expected none (cycle %0d)",
                         redirect_addr, cyc);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("redirect_addr", redirect_addr, e.addr);
                chk("redirect_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bju0_vld       = 1'b0;
        bju1_vld       = 1'b0;
        rob_commit_vld = 1'b0;
        exc_vld        = 1'b0;
    endtask

    task automatic bju(input int port, input logic [C_W-1:0] idx, input logic [63:0] a);
        if (port == 0) begin
            bju0_vld = 1'b1; bju0_rob_idx = idx; bju0_addr = a;
        end else begin
            bju1_vld = 1'b1; bju1_rob_idx = idx; bju1_addr = a;
        end
    endtask

    task automatic commit_exp(input logic [C_W-1:0] idx, input logic [63:0] a);
        exp_t e;
        rob_commit_vld = 1'b1;
        rob_commit_idx = idx;
        e.addr = a;
        e.cyc  = cyc + 1;
        q_exp.push_back(e);
        tick();
        clr();
    endtask

    task automatic commit_none(input logic [C_W-1:0] idx);
        rob_commit_vld = 1'b1;
        rob_commit_idx = idx;
        tick();
        clr();
        chk("no_redirect", {63'h0, redirect_vld}, 64'h0);
    endtask

    task automatic exc_exp(input logic [63:0] a);
        exp_t e;
        exc_vld  = 1'b1;
        exc_addr = a;
        e.addr = a;
        e.cyc  = cyc + 1;
        q_exp.push_back(e);
        tick();
        clr();
    endtask

    // Called in the REDIR cycle: flush/stall high for FLUSH_CYCLES+1 cycles.
    task automatic flush_window();
        for (int i = 0; i <= C_F; i++) begin
            chk("flush_high", {63'h0, flush}, 64'h1);
            chk("stall_high", {63'h0, y_stall_ctrl}, 64'h1);
            tick();
        end
        chk("flush_low", {63'h0, flush}, 64'h0);
        chk("stall_low", {63'h0, y_stall_ctrl}, 64'h0);
    endtask

    initial begin
        logic [31:0] exp_pr, exp_pf;
        clr();
        bju0_rob_idx = '0; bju1_rob_idx = '0; rob_commit_idx = '0;
        bju0_addr = 64'h0; bju1_addr = 64'h0; exc_addr = 64'h0;
        rob_head_idx = '0;
        rst_clk = 1'b1;
        #1 rst_clk = 1'b0;
        #20;
        chk("rst_redirect_vld", {63'h0, redirect_vld}, 64'h0);
        chk("rst_flush", {63'h0, flush}, 64'h0);
        chk("rst_stall", {63'h0, y_stall_ctrl}, 64'h0);
        chk("rst_redirect_addr", redirect_addr, 64'h0);
        chk("rst_perf_redir", {32'h0, perf_redirect_cnt}, 64'h0);
        chk("rst_perf_flush", {32'h0, perf_flush_cnt}, 64'h0);
        tick();
        rst_clk = 1'b1;
        tick();

        // Single mispredict, then a second one for the perf totals
        bju(0, 5'd3, 64'h8000_0100);
        tick(); clr(); tick(); tick();
        commit_exp(5'd3, 64'h8000_0100);
        flush_window();
        bju(1, 5'd9, 64'h8000_0200);
        tick(); clr();
        commit_exp(5'd9, 64'h8000_0200);
        flush_window();
`ifdef IDU_REDIRECT_PERF_EN
        exp_pr = 32'd2; exp_pf = 32'd6;
`else
        exp_pr = 32'd0; exp_pf = 32'd0;
`endif
        chk("perf_redirect_cnt", {32'h0, perf_redirect_cnt}, {32'h0, exp_pr});
        chk("perf_flush_cnt", {32'h0, perf_flush_cnt}, {32'h0, exp_pf});

        // Oldest wins; younger later arrival rejected
        bju(0, 5'd6, 64'hA);
        bju(1, 5'd2, 64'hB);
        tick(); clr();
        bju(0, 5'd4, 64'hBAD4);
        tick(); clr();
        commit_none(5'd6);
        commit_none(5'd4);
        commit_exp(5'd2, 64'hB);
        flush_window();

        // Equal indices: port 0 wins
        bju(0, 5'd7, 64'h7700);
        bju(1, 5'd7, 64'h7711);
        tick(); clr();
        commit_exp(5'd7, 64'h7700);
        flush_window();

        // Wrap-around ages with head=30
        rob_head_idx = 5'd30;
        bju(0, 5'd1, 64'hD);
        tick(); clr();
        bju(1, 5'd31, 64'hC);
        tick(); clr();
        commit_exp(5'd31, 64'hC);
        flush_window();
        commit_none(5'd1);
        rob_head_idx = 5'd0;

        // Exception during FLUSH restarts the window
        bju(0, 5'd3, 64'h3333);
        tick(); clr();
        commit_exp(5'd3, 64'h3333);
        tick();
        exc_exp(64'h8000_0000);
        flush_window();

        // Exception drops a pending entry
        bju(0, 5'd5, 64'h5555);
        tick(); clr();
        exc_exp(64'h9000_0000);
        flush_window();
        commit_none(5'd5);

        // Exception beats a same-cycle commit match
        bju(1, 5'd8, 64'h8888);
        tick(); clr();
        rob_commit_vld = 1'b1;
        rob_commit_idx = 5'd8;
        exc_exp(64'hA000_0000);
        flush_window();
        commit_none(5'd8);

        // Asynchronous reset in FLUSH
        bju(0, 5'd12, 64'hC0C0);
        tick(); clr();
        commit_exp(5'd12, 64'hC0C0);
        tick();
        #2 rst_clk = 1'b0;
        #1;
        chk("rstmid_flush", {63'h0, flush}, 64'h0);
        chk("rstmid_stall", {63'h0, y_stall_ctrl}, 64'h0);
        chk("rstmid_redirect_vld", {63'h0, redirect_vld}, 64'h0);
        chk("rstmid_perf_redir", {32'h0, perf_redirect_cnt}, 64'h0);
        tick();
        rst_clk = 1'b1;
        tick();
        commit_none(5'd12);

        // Pending entry lost across reset
        bju(0, 5'd20, 64'h2020);
        tick(); clr();
        #2 rst_clk = 1'b0;
        tick();
        rst_clk = 1'b1;
        tick();
        commit_none(5'd20);

        tick(); tick(); tick();
        chk("queue_empty", 64'(q_exp.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
